id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-forwarding stage that feeds the ALU. It captures decoded
//  operands and control from ID, and resolves EX/MEM and MEM/WB forwarding. It drives ALU r1/r2,
//  controle, branch_eq and branch_neq. It also detects load-use hazards and inserts a bubble.
// PARAMETERS
//  DATA_W      32  datapath width (r1/r2/immediate/results)
//  REG_AW       5  register-file address width
//  CTRL_W       4  ALU operation code width (controle)
// PORTS
//  clk             in   1       single clock, all state updates on rising edge
//  rst_n           in   1       synchronous reset, active low
//  stall           in   1       global hold (memory wait); freezes this stage
//  flush           in   1       squash stage contents (taken branch)
//  id_valid        in   1       ID holds a real instruction
//  id_rs_data      in   DATA_W  register-file read port A
//  id_rt_data      in   DATA_W  register-file read port B
//  id_imm          in   DATA_W  sign-extended immediate
//  id_rs/id_rt/id_rd in REG_AW  source and destination register addresses
//  id_alu_ctrl     in   CTRL_W  ALU operation code
//  id_alu_src      in   1       1: r2 = immediate, 0: r2 = forwarded rt
//  id_reg_dst      in   1       1: dest = rd, 0: dest = rt
//  id_branch_eq/id_branch_neq/id_reg_write/id_mem_read/id_mem_write/id_mem_to_reg in 1 each
//  exmem_reg_write in 1; exmem_rd in REG_AW; exmem_result in DATA_W   (EX/MEM forward source)
//  memwb_reg_write in 1; memwb_rd in REG_AW; memwb_result in DATA_W   (MEM/WB forward source)
//  r1, r2          out  DATA_W  ALU operands
//  controle        out  CTRL_W  ALU operation code
//  branch_eq, branch_neq out 1  ALU compare enables
//  ex_valid        out  1       EX holds a real instruction
//  ex_store_data   out  DATA_W  forwarded rt value for stores
//  ex_dest         out  REG_AW  write-back register address
//  ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg out 1 each
//  load_use_stall  out  1       combinational; upstream must hold PC and IF/ID when high
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): every registered field and all outputs derived from them become 0.
//    This covers ex_valid, all control bits, ex_dest, operands and controle (AND op, harmless).
//  - Update priority at each edge: reset > flush > stall > load_use_stall > load.
//  - flush: load a bubble. A bubble sets ex_valid=0, all control bits 0 (branch_eq/neq,
//    reg_write, mem_*), data fields 0, and controle=4'b0000.
//  - stall: all registers hold; load_use_stall is still computed but does not insert a bubble.
//  - load_use_stall = ex_valid & ex_mem_read & ex_dest!=0 & id_valid &
//    (ex_dest==id_rs | ex_dest==id_rt). When it is set and no stall/flush is active, load a bubble.
//  - load: capture all id_* fields with ex_valid=id_valid. ex_dest = id_reg_dst ? id_rd : id_rt.
//    If id_valid=0, control bits are forced to 0.
//  - Latency: an ID instruction appears on the outputs exactly 1 cycle after the loading edge.
//  - Forwarding (combinational from registered rs/rt and the forward sources), operand A:
//    exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs -> exmem_result (highest priority);
//    else memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs -> memwb_result;
//    else the registered rs data. Operand B (fwd_b) is resolved the same way using ex_rt.
//  - r1 = fwd_a; r2 = ex_alu_src ? ex_imm : fwd_b; ex_store_data = fwd_b regardless of alu_src.
//  - Register 0 is never forwarded, even when a source claims reg_write to address 0.
//  - Both sources matching: EX/MEM wins (newest value).
//  - A bubble drives branch_eq=branch_neq=0, so ALU zero=0 and no spurious branch occurs.
// TESTING
//  1 reset: rst_n=0 for 2 cycles with id_* nonzero -> ex_valid=0, r1=r2=0, all ctrl 0, controle=0
//  2 pass-through: id_rs_data=5, id_imm=7, alu_src=1, ctrl=0010, no fwd -> next cycle r1=5, r2=7, controle=0010
//  3 forward priority: ex_rs=3, exmem_rd=3 (wr, 0xAA), memwb_rd=3 (wr, 0xBB) -> r1=0xAA; EX/MEM wr off -> r1=0xBB; rd=0 both -> rs data
//  4 load-use: EX lw dest=8; ID add rs=8 -> load_use_stall=1, next cycle ex_valid=0, reg_write=0; then add loads normally
//  5 stall vs flush: stall=1 for 3 cycles -> outputs frozen; stall=1 and flush=1 -> bubble loaded
//  6 sw forward: alu_src=1, ex_rt=9, memwb_rd=9 wr 0x1234 -> r2=imm, ex_store_data=0x1234

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Captures decoded operands and control from ID. Inserts a bubble on flush
// or on a load-use hazard. Resolves ALU operands combinationally from the
// registered source addresses.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_branch_eq,
  input  logic              id_branch_neq,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [CTRL_W-1:0] controle,
  output logic              branch_eq,
  output logic              branch_neq,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_stall
);

  // All-zero value of this struct is the bubble (and the reset state).
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              branch_eq;
    logic              branch_neq;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;

  stage_t stage_reg;
  stage_t stage_next;
  stage_t id_entry;

  // Pack the ID fields. Control bits are masked when ID holds no instruction.
  always_comb begin
    id_entry            = '0;
    id_entry.valid      = id_valid;
    id_entry.rs_data    = id_rs_data;
    id_entry.rt_data    = id_rt_data;
    id_entry.imm        = id_imm;
    id_entry.rs         = id_rs;
    id_entry.rt         = id_rt;
    id_entry.dest       = id_reg_dst ? id_rd : id_rt;
    id_entry.alu_ctrl   = id_alu_ctrl;
    id_entry.alu_src    = id_alu_src;
    id_entry.branch_eq  = id_valid & id_branch_eq;
    id_entry.branch_neq = id_valid & id_branch_neq;
    id_entry.reg_write  = id_valid & id_reg_write;
    id_entry.mem_read   = id_valid & id_mem_read;
    id_entry.mem_write  = id_valid & id_mem_write;
    id_entry.mem_to_reg = id_valid & id_mem_to_reg;
  end

  // A load in EX whose destination is read by the instruction in ID.
  assign load_use_stall = stage_reg.valid & stage_reg.mem_read &
                          (stage_reg.dest != '0) & id_valid &
                          ((stage_reg.dest == id_rs) | (stage_reg.dest == id_rt));

  // Next-state selection: flush beats stall, and stall beats the hazard bubble.
  always_comb begin
    stage_next = stage_reg;
    if (flush) begin
      stage_next = '0;
    end else if (stall) begin
      stage_next = stage_reg;
    end else if (load_use_stall) begin
      stage_next = '0;
    end else begin
      stage_next = id_entry;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Operand forwarding. Index 0 resolves rs (operand A), index 1 resolves rt.
  // EX/MEM is checked first because it holds the newest value. Register 0
  // is never forwarded, whatever the source claims.
  logic [REG_AW-1:0] src_addr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [DATA_W-1:0] fwd_data [2];

  assign src_addr[0] = stage_reg.rs;
  assign src_addr[1] = stage_reg.rt;
  assign src_data[0] = stage_reg.rs_data;
  assign src_data[1] = stage_reg.rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_exmem;
      logic hit_memwb;
      assign hit_exmem = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == src_addr[gi]);
      assign hit_memwb = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == src_addr[gi]);
      assign fwd_data[gi] = hit_exmem ? exmem_result :
                            hit_memwb ? memwb_result : src_data[gi];
    end
  endgenerate

  assign r1            = fwd_data[0];
  assign r2            = stage_reg.alu_src ? stage_reg.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign controle      = stage_reg.alu_ctrl;
  assign branch_eq     = stage_reg.branch_eq;
  assign branch_neq    = stage_reg.branch_neq;
  assign ex_valid      = stage_reg.valid;
  assign ex_dest       = stage_reg.dest;
  assign ex_reg_write  = stage_reg.reg_write;
  assign ex_mem_read   = stage_reg.mem_read;
  assign ex_mem_write  = stage_reg.mem_write;
  assign ex_mem_to_reg = stage_reg.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, pass-through, forwarding
// priority, load-use bubble, stall/flush and store-data forwarding.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_dst, id_branch_eq, id_branch_neq;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] r1, r2, ex_store_data;
  logic [3:0]  controle;
  logic        branch_eq, branch_neq, ex_valid;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        load_use_stall;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_branch_eq(id_branch_eq), .id_branch_neq(id_branch_neq),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .r1(r1), .r2(r2), .controle(controle), .branch_eq(branch_eq), .branch_neq(branch_neq),
    .ex_valid(ex_valid), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_reg_dst = 0; id_branch_eq = 0; id_branch_neq = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    stall = 0; flush = 0;
    clear_fwd();

    // 1: reset with busy ID inputs
    rst_n = 0;
    id_valid = 1; id_rs_data = 32'hFFFF_0001; id_rt_data = 32'hFFFF_0002; id_imm = 32'hFFFF_0003;
    id_rs = 5'd7; id_rt = 5'd6; id_rd = 5'd5; id_alu_ctrl = 4'hF;
    id_alu_src = 1; id_reg_dst = 1; id_branch_eq = 1; id_branch_neq = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
    step(); step();
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_r1", r1, 0);
    check("rst_r2", r2, 0);
    check("rst_controle", 32'(controle), 0);
    check("rst_ctrl_bits", 32'({branch_eq, branch_neq, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 0);
    check("rst_dest", 32'(ex_dest), 0);
    check("rst_lus", 32'(load_use_stall), 0);

    // 2: pass-through, one-cycle latency
    rst_n = 1;
    clear_id();
    id_valid = 1; id_rs_data = 5; id_imm = 7; id_alu_src = 1; id_alu_ctrl = 4'b0010;
    id_rs = 1; id_rt = 2; id_rd = 3; id_reg_dst = 1; id_reg_write = 1; id_branch_neq = 1;
    #1;
    check("pt_before_edge_valid", 32'(ex_valid), 0);
    step();
    check("pt_r1", r1, 5);
    check("pt_r2", r2, 7);
    check("pt_controle", 32'(controle), 32'b0010);
    check("pt_dest_rd", 32'(ex_dest), 3);
    check("pt_reg_write", 32'(ex_reg_write), 1);
    check("pt_branch", 32'({branch_eq, branch_neq}), 32'b01);

    // 3: forwarding priority on operand A
    clear_id();
    id_valid = 1; id_rs = 3; id_rs_data = 32'h11; id_rt = 4; id_rt_data = 32'h22;
    step();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    #1;
    check("fwd_both_exmem_wins", r1, 32'hAA);
    check("fwd_r2_nomatch", r2, 32'h22);
    exmem_reg_write = 0;
    #1;
    check("fwd_memwb", r1, 32'hBB);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    check("fwd_rd0_none", r1, 32'h11);
    memwb_rd = 4;
    #1;
    check("fwd_b_memwb", r2, 32'hBB);
    clear_fwd();

    // 4: load-use hazard (lw dest=8, then add rs=8)
    clear_id();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_reg_dst = 0; id_rs = 1; id_rt = 8; id_alu_src = 1; id_imm = 4;
    step();
    check("lw_mem_read", 32'(ex_mem_read), 1);
    check("lw_dest_rt", 32'(ex_dest), 8);
    clear_id();
    id_valid = 1; id_rs = 8; id_rt = 2; id_rd = 10; id_reg_dst = 1; id_reg_write = 1;
    id_alu_ctrl = 4'b0010; id_rs_data = 32'h33;
    #1;
    check("lus_asserted", 32'(load_use_stall), 1);
    step();
    check("lus_bubble_valid", 32'(ex_valid), 0);
    check("lus_bubble_reg_write", 32'(ex_reg_write), 0);
    check("lus_cleared", 32'(load_use_stall), 0);
    step();
    check("add_valid", 32'(ex_valid), 1);
    check("add_dest", 32'(ex_dest), 10);
    check("add_r1", r1, 32'h33);

    // 5: stall freezes the stage for 3 cycles, then stall+flush loads a bubble
    clear_id();
    id_valid = 1; id_rs_data = 32'h44; id_alu_ctrl = 4'b0101; id_rt = 12; id_reg_write = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_r1", r1, 32'h33);
      check("stall_controle", 32'(controle), 32'b0010);
      check("stall_dest", 32'(ex_dest), 10);
    end
    flush = 1;
    step();
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_controle", 32'(controle), 0);
    check("flush_r1", r1, 0);
    check("flush_reg_write", 32'(ex_reg_write), 0);
    stall = 0; flush = 0;

    // invalid ID: control bits forced low
    clear_id();
    id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_branch_eq = 1;
    step();
    check("invalid_ctrl", 32'({ex_valid, ex_reg_write, ex_mem_write, branch_eq}), 0);

    // 6: store-data forwarding with alu_src=1
    clear_id();
    id_valid = 1; id_rs = 1; id_rt = 9; id_rt_data = 32'h55; id_imm = 32'h10;
    id_alu_src = 1; id_mem_write = 1;
    step();
    memwb_reg_write = 1; memwb_rd = 9; memwb_result = 32'h1234;
    #1;
    check("sw_r2_imm", r2, 32'h10);
    check("sw_store_fwd", ex_store_data, 32'h1234);
    check("sw_mem_write", 32'(ex_mem_write), 1);
    clear_fwd();

    // register 0 is never forwarded
    clear_id();
    id_valid = 1; id_rs = 0; id_rs_data = 32'h77;
    step();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
    #1;
    check("r0_no_fwd", r1, 32'h77);
    clear_fwd();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
